// File: rtl/risci_fetch_unit_pkg.sv
// risci_pkg: shared widths, queue entry type and fetch FSM states for the
// risci instruction fetch front-end.
package risci_pkg;

    // Virtual address and instruction widths used throughout the core
    localparam int VLEN = 64;
    localparam int ILEN = 32;

    // One prefetch queue slot: the word and the PC it was fetched from
    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    // IDLE: no request on the bus
    // REQ : a live request whose response will be enqueued
    // DROP: a request made stale by a redirect, waiting only to be retired
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // Force word alignment of a fetch address
    function automatic logic [VLEN-1:0] alignPc(input logic [VLEN-1:0] pc);
        return pc & ~(VLEN'(3));
    endfunction

endpackage

// File: rtl/risci_fetch_unit_queue.sv
// risci_fetch_queue: DEPTH-entry FIFO of fetch_entry_t feeding the decoder.
// Synchronous flush beats push and pop; the head output holds the most
// recently popped entry while the queue is empty.
module risci_fetch_queue
    import risci_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  fetch_entry_t             i_pushEntry,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    r_mem [DEPTH];
    fetch_entry_t    r_lastPop;
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_doPush;
    logic            w_doPop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_doPop  = i_pop && !w_empty && !i_flush;
    assign w_doPush = i_push && !i_flush && (!w_full || w_doPop);

    // Entry storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushEntry;
        end
    end

    // Read/write indices and occupancy, cleared together on flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            unique case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Remember the entry handed out last so the head is stable when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastPop <= '0;
        end else if (w_doPop) begin
            r_lastPop <= r_mem[r_rdPtr];
        end
    end

    assign o_head  = w_empty ? r_lastPop : r_mem[r_rdPtr];
    assign o_valid = !w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/risci_fetch_unit.sv
// risci_fetch_unit: instruction fetch front-end for risci_core.
// Issues one outstanding word request at a time, buffers responses with their
// PC in risci_fetch_queue and hands them to decode over valid/ready. A redirect
// flushes the queue, restarts at the new PC and retires any stale request.
// Optional build macro RISCI_FETCH_PERF_EN adds fetch/stall counters.
module risci_fetch_unit
    import risci_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [VLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [VLEN-1:0]  imem_addr,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [ILEN-1:0]  imem_data,
    output logic [ILEN-1:0]  inst,
    output logic [VLEN-1:0]  inst_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    input  logic             redirect,
    input  logic [VLEN-1:0]  redirect_pc,
    input  logic             hlt
`ifdef RISCI_FETCH_PERF_EN
    ,
    output logic [63:0]      perf_fetched,
    output logic [63:0]      perf_stall
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 2;

    fetch_state_t     r_state;
    fetch_state_t     w_nextState;
    logic [VLEN-1:0]  r_fetchPc;
    logic [VLEN-1:0]  r_dropAddr;

    logic [PW:0]      w_count;
    logic [CW-1:0]    w_countNext;
    logic             w_qValid;
    logic             w_push;
    logic             w_pop;
    logic             w_canIssue;
    fetch_entry_t     w_pushEntry;
    fetch_entry_t     w_head;

    // A redirect suppresses both the same-cycle pop and the same-cycle push
    assign w_pop       = w_qValid && inst_ready && !redirect;
    assign w_push      = (r_state == REQ) && imem_ack && !redirect;
    assign w_countNext = CW'(w_count) + CW'(w_push) - CW'(w_pop);
    assign w_canIssue  = !hlt && !redirect && (w_countNext < CW'(DEPTH));

    assign w_pushEntry.pc   = r_fetchPc;
    assign w_pushEntry.inst = imem_data;

    risci_fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pushEntry (w_pushEntry),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_head      (w_head),
        .o_valid     (w_qValid),
        .o_count     (w_count)
    );

    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;
    assign inst_valid = w_qValid;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and memory-side outputs; a request is held until acked
    always_comb begin
        w_nextState = r_state;
        imem_req    = 1'b0;
        imem_addr   = r_fetchPc;
        unique case (r_state)
            IDLE: begin
                if (w_canIssue) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_nextState = w_canIssue ? REQ : IDLE;
                end else if (redirect) begin
                    w_nextState = DROP;
                end
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = r_dropAddr;
                if (imem_ack) begin
                    w_nextState = w_canIssue ? REQ : IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Fetch PC advances on each accepted word and jumps on redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetchPc  <= alignPc(RESET_PC);
            r_dropAddr <= alignPc(RESET_PC);
        end else begin
            if (redirect) begin
                r_fetchPc <= alignPc(redirect_pc);
            end else if (w_push) begin
                r_fetchPc <= r_fetchPc + VLEN'(4);
            end
            if ((r_state == REQ) && redirect && !imem_ack) begin
                r_dropAddr <= r_fetchPc;
            end
        end
    end

`ifdef RISCI_FETCH_PERF_EN
    logic [63:0] r_perfFetched;
    logic [63:0] r_perfStall;

    // Saturating counters for accepted words and starved non-halted cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perfFetched <= '0;
            r_perfStall   <= '0;
        end else begin
            if (w_push && (r_perfFetched != '1)) begin
                r_perfFetched <= r_perfFetched + 64'd1;
            end
            if (!w_qValid && !hlt && (r_perfStall != '1)) begin
                r_perfStall <= r_perfStall + 64'd1;
            end
        end
    end

    assign perf_fetched = r_perfFetched;
    assign perf_stall   = r_perfStall;
`endif

endmodule

// File: tb/tb_risci_fetch_unit.sv
// Testbench for risci_fetch_unit: directed scenarios followed by random
// ready/hlt/redirect traffic against a variable-latency memory, checked
// against a queue-level reference of what decode should see.
module tb_risci_fetch_unit;
    import risci_pkg::*;

    localparam int          DEPTH   = 4;
    localparam logic [63:0] BASE_PC = 64'h1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        hlt = 1'b0;
`ifdef RISCI_FETCH_PERF_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_stall;
`endif

    always #5 clk = ~clk;

    risci_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (BASE_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .hlt         (hlt)
`ifdef RISCI_FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    // Instruction memory: word content is a hash of its address
    function automatic logic [31:0] memWord(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13579BDF;
    endfunction

    int latSetting = 0;
    bit latRandom  = 1'b0;
    int curLat     = 0;
    int memWait    = 0;

    assign imem_data = memWord(imem_addr);
    assign imem_ack  = imem_req && (memWait >= (latRandom ? curLat : latSetting));

    // Memory responder: acks after the chosen number of wait cycles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            memWait <= 0;
            curLat  <= 0;
        end else if (imem_ack) begin
            memWait <= 0;
            curLat  <= $urandom_range(0, 3);
        end else if (imem_req) begin
            memWait <= memWait + 1;
        end
    end

    // Reference: what decode should see, as a plain queue of {pc, word}
    fetch_entry_t mQ[$];
    logic [63:0]  mFetchPc;
    bit           prevReq, prevAck, prevHlt, prevRedirect, stale;
    logic [63:0]  prevAddr;
    int           prevSize;
    int           pushCount = 0;
    int           popCount = 0;
    int           startCount = 0;
    logic [63:0]  lastStartAddr = 64'd0;

    int checks = 0;
    int errors = 0;

    int          firstValid, p0, s0;
    logic [63:0] staleAddr, expNext;
    bit          staleSeen, sawZero;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic h, input logic rd,
                                 input logic [63:0] rpc);
        inst_ready  = rdy;
        hlt         = h;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic modelReset();
        mQ.delete();
        mFetchPc     = BASE_PC;
        prevReq      = 1'b0;
        prevAck      = 1'b0;
        prevHlt      = 1'b0;
        prevRedirect = 1'b0;
        stale        = 1'b0;
        prevAddr     = 64'd0;
        prevSize     = 0;
    endtask

    // One cycle: called at a negedge with inputs applied; checks, updates, advances
    task automatic step();
        fetch_entry_t e;
        bit newStart;
        #1;
        checkOutput("instValid", 64'(inst_valid), 64'(mQ.size() != 0));
        if (mQ.size() != 0) begin
            checkOutput("instPc", inst_pc, mQ[0].pc);
            checkOutput("instWord", 64'(inst), 64'(mQ[0].inst));
        end
        if (prevReq && !prevAck) begin
            checkOutput("reqHeld", 64'(imem_req), 64'd1);
            checkOutput("addrHeld", imem_addr, prevAddr);
        end
        newStart = imem_req && !(prevReq && !prevAck);
        if (newStart) begin
            checkOutput("startAddr", imem_addr, mFetchPc);
            checkOutput("startAfterHlt", 64'(prevHlt), 64'd0);
            checkOutput("startAfterRedir", 64'(prevRedirect), 64'd0);
            checkOutput("startCredit", 64'(prevSize < DEPTH), 64'd1);
            startCount++;
            lastStartAddr = imem_addr;
            stale = 1'b0;
        end
        if (imem_req) begin
            checkOutput("addrAlign", 64'(imem_addr[1:0]), 64'd0);
        end
        if (imem_req && redirect) begin
            stale = 1'b1;
        end
        if (inst_valid && inst_ready && !redirect && (mQ.size() != 0)) begin
            void'(mQ.pop_front());
            popCount++;
        end
        if (imem_req && imem_ack && !stale) begin
            checkOutput("noOverflow", 64'(mQ.size() < DEPTH), 64'd1);
            e.pc   = mFetchPc;
            e.inst = memWord(mFetchPc);
            mQ.push_back(e);
            mFetchPc = mFetchPc + 64'd4;
            pushCount++;
        end
        if (redirect) begin
            mQ.delete();
            mFetchPc = redirect_pc & ~64'd3;
        end
        prevReq      = imem_req;
        prevAck      = imem_ack;
        prevAddr     = imem_addr;
        prevHlt      = hlt;
        prevRedirect = redirect;
        prevSize     = mQ.size();
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must drop immediately, release at a negedge
    task automatic applyReset();
        rst = 1'b1;
        #1;
        checkOutput("rstReq", 64'(imem_req), 64'd0);
        checkOutput("rstValid", 64'(inst_valid), 64'd0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstInst", 64'(inst), 64'd0);
        checkOutput("rstInstPc", inst_pc, 64'd0);
        checkOutput("rstAddr", imem_addr, BASE_PC);
        rst = 1'b0;
    endtask

    initial begin
        applyReset();

        // Zero-wait memory, always ready: one word per cycle from BASE_PC
        latSetting = 0;
        latRandom  = 1'b0;
        firstValid = -1;
        p0 = popCount;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
            if (inst_valid && (firstValid < 0)) firstValid = i;
            step();
        end
        checkOutput("firstValidCycle", 64'(firstValid), 64'd2);
        checkOutput("throughput", 64'(popCount - p0), 64'd10);

        // Core stalled: queue fills to DEPTH and fetch stops
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h4000);
        step();
        p0 = pushCount;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
            step();
        end
        checkOutput("fullPushes", 64'(pushCount - p0), 64'd4);
        checkOutput("fullReqIdle", 64'(imem_req), 64'd0);
        s0 = startCount;
        for (int i = 0; i < 40 && startCount == s0; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
            step();
        end
        checkOutput("resumeSeen", 64'(startCount != s0), 64'd1);
        checkOutput("resumeAddr", lastStartAddr, 64'h4010);

        // Slow memory, redirect while a request is outstanding
        latSetting = 3;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
            step();
        end
        for (int i = 0; i < 40 && !(imem_req && memWait == 0); i++) step();
        checkOutput("freshReqSeen", 64'(imem_req && memWait == 0), 64'd1);
        step();
        staleAddr = imem_addr;
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h2002);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        staleSeen = 1'b0;
        s0 = startCount;
        for (int i = 0; i < 40 && startCount == s0; i++) begin
            if (inst_valid && inst_pc == staleAddr) staleSeen = 1'b1;
            step();
        end
        checkOutput("redirStartAddr", lastStartAddr, 64'h2000);
        for (int i = 0; i < 12; i++) begin
            if (inst_valid && inst_pc == staleAddr) staleSeen = 1'b1;
            step();
        end
        checkOutput("staleAbsent", 64'(staleSeen), 64'd0);

        // Redirect coinciding with ack and a handshake
        latSetting = 0;
        for (int i = 0; i < 20 && !(inst_valid && imem_req); i++) step();
        checkOutput("busyBeforeFlush", 64'(inst_valid && imem_req && imem_ack), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h3000);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        checkOutput("flushValid", 64'(inst_valid), 64'd0);
        checkOutput("flushReq", 64'(imem_req), 64'd0);
        checkOutput("flushAddr", imem_addr, 64'h3000);
        for (int i = 0; i < 8; i++) step();

        // hlt during an outstanding request: it completes, nothing new issues
        latSetting = 3;
        for (int i = 0; i < 20 && !imem_req; i++) step();
        p0 = pushCount;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 64'd0);
            step();
        end
        checkOutput("hltPushes", 64'(pushCount - p0), 64'd1);
        checkOutput("hltReqIdle", 64'(imem_req), 64'd0);
        expNext = mFetchPc;
        s0 = startCount;
        for (int i = 0; i < 20 && startCount == s0; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
            step();
        end
        checkOutput("hltResumeAddr", lastStartAddr, expNext);

        // Address wrap at the top of the address space
        latSetting = 0;
        applyStimulus(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        sawZero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (inst_valid && inst_pc == 64'd0) sawZero = 1'b1;
            step();
        end
        checkOutput("wrapToZero", 64'(sawZero), 64'd1);

        // Asynchronous reset in the middle of a request
        latSetting = 3;
        for (int i = 0; i < 20 && !imem_req; i++) step();
        #2;
        applyReset();
        s0 = startCount;
        for (int i = 0; i < 20 && startCount == s0; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
            step();
        end
        checkOutput("rstFirstAddr", lastStartAddr, BASE_PC);

        // Random traffic with random memory latency
        latRandom = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                          $urandom_range(0, 31) == 0, {$urandom, $urandom});
            step();
        end
        p0 = popCount;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
            step();
        end
        checkOutput("liveness", 64'(popCount > p0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
